// File: rtl/orb_pkg.sv
// Shared definitions for the ORB frame RAM reader/writer pair.
// Holds the word/address widths, the default sync word and the reader FSM encoding.
package orb_pkg;

    localparam int WORD_BITS = 12;
    localparam int ADDR_BITS = 11;
    localparam logic [WORD_BITS-1:0] SYNC_WORD_DEF = 12'hF0F;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LATCH = 3'd2,
        ST_SHIFT = 3'd3,
        ST_NEXT  = 3'd4
    } orb_state_t;

    function automatic logic [ADDR_BITS-1:0] next_slot(input logic [ADDR_BITS-1:0] slot);
        return slot + 11'd1;
    endfunction

endpackage

// File: rtl/orb_bit_timer.sv
// Serial bit timing: BIT_DIV clocks per bit, 12 bits per word.
// Produces a registered strobe on the first clock of every bit and end-of-bit/word flags.
module orb_bit_timer
    import orb_pkg::*;
#(
    parameter int BIT_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_strb,
    output logic o_bit_end,
    output logic o_done
);

    localparam int DIV_W = $clog2(BIT_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV - 1);
    localparam logic [3:0]       BIT_LAST = 4'(WORD_BITS - 1);

    logic [DIV_W-1:0] r_div;
    logic [3:0]       r_bit;
    logic             r_strb;

    assign o_bit_end = (r_div == DIV_LAST);
    assign o_done    = o_bit_end && (r_bit == BIT_LAST);
    assign o_strb    = r_strb;

    // Divider and bit counters; clearing arms the strobe for the first bit of the word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div  <= '0;
            r_bit  <= 4'd0;
            r_strb <= 1'b0;
        end else if (i_clr) begin
            r_div  <= '0;
            r_bit  <= 4'd0;
            r_strb <= 1'b1;
        end else if (i_en) begin
            if (o_bit_end) begin
                r_div <= '0;
                if (r_bit == BIT_LAST) begin
                    r_bit  <= 4'd0;
                    r_strb <= 1'b0;
                end else begin
                    r_bit  <= r_bit + 4'd1;
                    r_strb <= 1'b1;
                end
            end else begin
                r_div  <= r_div + DIV_W'(1);
                r_strb <= 1'b0;
            end
        end else begin
            r_strb <= 1'b0;
        end
    end

endmodule

// File: rtl/orb_word_reader.sv
// Reads one frame of 12-bit words from RAM per start edge and serialises it MSB first.
// Slot 0 carries SYNC_WORD instead of RAM address 0; start edges while busy flag an overrun.
module orb_word_reader
    import orb_pkg::*;
#(
    parameter int                   FRAME_WORDS = 2048,
    parameter int                   BIT_DIV     = 4,
    parameter logic [WORD_BITS-1:0] SYNC_WORD   = SYNC_WORD_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WORD_BITS-1:0] rdData,
    output logic [ADDR_BITS-1:0] rdAddr,
    output logic                 RE,
    output logic                 serOut,
    output logic                 bitStrb,
    output logic                 frameSync,
    output logic                 busy,
    output logic                 test
);

    localparam logic [ADDR_BITS-1:0] LAST_SLOT = ADDR_BITS'(FRAME_WORDS - 1);

    orb_state_t           r_state;
    logic [1:0]           r_sync;
    logic                 r_sync_d;
    logic [ADDR_BITS-1:0] r_slot;
    logic [WORD_BITS-1:0] r_shift;
    logic [ADDR_BITS-1:0] r_rdaddr;
    logic                 r_re;
    logic                 r_ser;
    logic                 r_fs;
    logic                 r_busy;
    logic                 r_test;

    logic                 w_edge;
    logic                 w_bit_end;
    logic                 w_done;
    logic [WORD_BITS-1:0] w_load;

    assign w_edge = r_sync[1] & ~r_sync_d;
    assign w_load = (r_slot == '0) ? SYNC_WORD : rdData;

    orb_bit_timer #(
        .BIT_DIV (BIT_DIV)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (r_state == ST_LATCH),
        .i_en      (r_state == ST_SHIFT),
        .o_strb    (bitStrb),
        .o_bit_end (w_bit_end),
        .o_done    (w_done)
    );

    // Frame sequencer: synchroniser, slot walk, RAM fetch, word shifter and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_sync   <= 2'b00;
            r_sync_d <= 1'b0;
            r_slot   <= '0;
            r_shift  <= '0;
            r_rdaddr <= '0;
            r_re     <= 1'b0;
            r_ser    <= 1'b0;
            r_fs     <= 1'b0;
            r_busy   <= 1'b0;
            r_test   <= 1'b0;
        end else begin
            r_sync   <= {r_sync[0], start};
            r_sync_d <= r_sync[1];
            r_re     <= 1'b0;
            // Any edge outside IDLE is an overrun, including the cycle that returns to IDLE.
            r_test   <= w_edge && (r_state != ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    if (w_edge) begin
                        r_busy  <= 1'b1;
                        r_slot  <= '0;
                        r_state <= ST_LATCH;
                    end
                end
                ST_FETCH: begin
                    r_state <= ST_LATCH;
                end
                ST_LATCH: begin
                    r_shift <= w_load;
                    r_ser   <= w_load[WORD_BITS-1];
                    r_fs    <= (r_slot == '0);
                    r_state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (w_bit_end) begin
                        if (w_done) begin
                            r_ser   <= 1'b0;
                            r_fs    <= 1'b0;
                            r_state <= ST_NEXT;
                        end else begin
                            r_shift <= {r_shift[WORD_BITS-2:0], 1'b0};
                            r_ser   <= r_shift[WORD_BITS-2];
                        end
                    end
                end
                ST_NEXT: begin
                    if (r_slot == LAST_SLOT) begin
                        r_slot   <= '0;
                        r_rdaddr <= '0;
                        r_busy   <= 1'b0;
                        r_state  <= ST_IDLE;
                    end else begin
                        r_slot   <= next_slot(r_slot);
                        r_rdaddr <= next_slot(r_slot);
                        r_re     <= 1'b1;
                        r_state  <= ST_FETCH;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign rdAddr    = r_rdaddr;
    assign RE        = r_re;
    assign serOut    = r_ser;
    assign frameSync = r_fs;
    assign busy      = r_busy;
    assign test      = r_test;

endmodule

// File: tb/tb_orb_word_reader.sv
// Scoreboard bench for orb_word_reader: a 4-word frame instance and a full 2048-word instance.
module tb_orb_word_reader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [11:0] rd_data;
    logic [10:0] rd_addr;
    logic        re;
    logic        ser_out;
    logic        bit_strb;
    logic        frame_sync;
    logic        busy;
    logic        test;

    logic        rst_b;
    logic        start_b;
    logic [11:0] rd_data_b;
    logic [10:0] rd_addr_b;
    logic        re_b;
    logic        ser_b;
    logic        strb_b;
    logic        fs_b;
    logic        busy_b;
    logic        test_b;

    logic [11:0] ram [0:3];

    int total = 0;
    int bad   = 0;

    logic [12:0] exp_q [$];
    logic [10:0] re_q  [$];

    int cyc      = 0;
    int strb_cnt = 0;
    int fs_cnt   = 0;
    int test_cnt = 0;

    int b_re_cnt  = 0;
    int b_seq_err = 0;
    int b_last    = 0;
    bit b_done    = 1'b0;

    orb_word_reader #(.FRAME_WORDS(4), .BIT_DIV(4), .SYNC_WORD(12'hF0F)) dut (
        .clk(clk), .rst(rst), .start(start), .rdData(rd_data), .rdAddr(rd_addr), .RE(re),
        .serOut(ser_out), .bitStrb(bit_strb), .frameSync(frame_sync), .busy(busy), .test(test)
    );

    orb_word_reader #(.FRAME_WORDS(2048), .BIT_DIV(2), .SYNC_WORD(12'hF0F)) dut_b (
        .clk(clk), .rst(rst_b), .start(start_b), .rdData(rd_data_b), .rdAddr(rd_addr_b), .RE(re_b),
        .serOut(ser_b), .bitStrb(strb_b), .frameSync(fs_b), .busy(busy_b), .test(test_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (re)   rd_data   <= ram[rd_addr[1:0]];
        if (re_b) rd_data_b <= {1'b0, rd_addr_b};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input logic [31:0] act);
        total++;
        bad++;
        $display("FAIL %s: got %0h expected nothing", name, act);
    endtask

    // Monitor for the 4-word instance: pops expected words/addresses as the DUT presents them.
    initial begin
        logic [12:0] cur;
        logic [11:0] word;
        int          bitn;
        int          last_strb;
        bit          re_prev;
        cur = '0; word = '0; bitn = 0; last_strb = 0; re_prev = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                bitn = 0; word = '0; re_prev = 1'b0;
            end else begin
                if (re) begin
                    chk("re_one_cycle", 32'(re_prev), 32'd0);
                    if (re_q.size() == 0) fail_now("re_unexpected", 32'(rd_addr));
                    else chk("re_addr", 32'(rd_addr), 32'(re_q.pop_front()));
                end
                re_prev = re;
                if (test)       test_cnt++;
                if (frame_sync) fs_cnt++;
                if (!busy) chk("ser_idle", 32'(ser_out), 32'd0);
                if (bit_strb) begin
                    strb_cnt++;
                    if (bitn == 0) begin
                        if (exp_q.size() == 0) begin
                            fail_now("word_unexpected", 32'(strb_cnt));
                            cur = 13'h1000;
                        end else begin
                            cur = exp_q.pop_front();
                            if (!cur[12]) chk("word_gap", 32'(cyc - last_strb), 32'd7);
                        end
                    end else begin
                        chk("bit_len", 32'(cyc - last_strb), 32'd4);
                    end
                    last_strb = cyc;
                    chk("frame_sync", 32'(frame_sync), 32'(cur[12]));
                    word = {word[10:0], ser_out};
                    bitn++;
                    if (bitn == 12) begin
                        chk("word", 32'(word), 32'(cur[11:0]));
                        bitn = 0;
                    end
                end
            end
        end
    end

    // Monitor for the 2048-word instance: RE count and strictly incrementing addresses.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_b && re_b) begin
                b_re_cnt++;
                if (int'(rd_addr_b) != b_last + 1) b_seq_err++;
                b_last = int'(rd_addr_b);
            end
        end
    end

    task automatic expect_frame();
        exp_q.push_back({1'b1, 12'hF0F});
        exp_q.push_back({1'b0, 12'hABC});
        exp_q.push_back({1'b0, 12'h001});
        exp_q.push_back({1'b0, 12'h800});
        re_q.push_back(11'd1);
        re_q.push_back(11'd2);
        re_q.push_back(11'd3);
    endtask

    task automatic clear_cnts();
        strb_cnt = 0; fs_cnt = 0; test_cnt = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        repeat (6) @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_strb(input int n, input string tag);
        int k;
        k = 0;
        while (strb_cnt < n && k < 5000) begin
            @(negedge clk); #1;
            k++;
        end
        chk({tag, "_strb_reached"}, 32'(strb_cnt >= n), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (!busy && k < 20) begin @(negedge clk); k++; end
        k = 0;
        while (busy && k < 3000) begin @(negedge clk); k++; end
        chk({tag, "_idle_reached"}, 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic frame_checks(input string tag, input int exp_test);
        chk({tag, "_strb_cnt"}, 32'(strb_cnt), 32'd48);
        chk({tag, "_fs_cnt"},   32'(fs_cnt),   32'd48);
        chk({tag, "_test_cnt"}, 32'(test_cnt), 32'(exp_test));
        chk({tag, "_rdaddr"},   32'(rd_addr),  32'd0);
        chk({tag, "_words_left"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_re_left"},  32'(re_q.size()), 32'd0);
    endtask

    // Full-size frame on the second instance.
    initial begin
        int k;
        rst_b = 1'b1; start_b = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_b = 1'b0;
        repeat (3) @(posedge clk);
        #1 start_b = 1'b1;
        repeat (8) @(posedge clk);
        #1 start_b = 1'b0;
        k = 0;
        while (!busy_b && k < 20) begin @(negedge clk); k++; end
        k = 0;
        while (busy_b && k < 60000) begin @(negedge clk); k++; end
        chk("big_idle_reached", 32'(busy_b), 32'd0);
        chk("big_re_cnt",  32'(b_re_cnt), 32'd2047);
        chk("big_last_re", 32'(b_last),   32'd2047);
        chk("big_seq",     32'(b_seq_err), 32'd0);
        chk("big_rdaddr",  32'(rd_addr_b), 32'd0);
        b_done = 1'b1;
    end

    initial begin
        rst = 1'b1; start = 1'b0;
        ram[0] = 12'h000; ram[1] = 12'hABC; ram[2] = 12'h001; ram[3] = 12'h800;
        repeat (3) @(negedge clk);
        chk("rst_re",      32'(re),         32'd0);
        chk("rst_rdaddr",  32'(rd_addr),    32'd0);
        chk("rst_ser",     32'(ser_out),    32'd0);
        chk("rst_strb",    32'(bit_strb),   32'd0);
        chk("rst_fs",      32'(frame_sync), 32'd0);
        chk("rst_busy",    32'(busy),       32'd0);
        chk("rst_test",    32'(test),       32'd0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (4) @(posedge clk);

        // Plain frame
        clear_cnts(); expect_frame();
        pulse_start();
        wait_idle("f1");
        frame_checks("f1", 0);

        // Overrun mid-frame
        clear_cnts(); expect_frame();
        pulse_start();
        wait_strb(20, "ovr");
        pulse_start();
        wait_idle("ovr");
        frame_checks("ovr", 1);
        repeat (200) @(negedge clk);
        chk("ovr_no_extra_busy", 32'(busy), 32'd0);
        chk("ovr_no_extra_strb", 32'(strb_cnt), 32'd48);

        // Reset during slot 2, then restart
        clear_cnts(); expect_frame();
        pulse_start();
        wait_strb(26, "abort");
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("abort_outputs", 32'({rd_addr, re, ser_out, bit_strb, frame_sync, busy, test}), 32'd0);
        exp_q.delete(); re_q.delete();
        @(posedge clk); #1 rst = 1'b0;
        repeat (4) @(posedge clk);
        clear_cnts(); expect_frame();
        pulse_start();
        wait_idle("restart");
        frame_checks("restart", 0);

        // Edge landing on the NEXT->IDLE cycle, start then held high
        clear_cnts(); expect_frame();
        pulse_start();
        wait_strb(48, "edge_end");
        @(posedge clk);
        @(posedge clk);
        #1 start = 1'b1;
        wait_idle("edge_end");
        frame_checks("edge_end", 1);
        repeat (100) @(negedge clk);
        chk("held_no_frame_busy", 32'(busy), 32'd0);
        chk("held_no_frame_strb", 32'(strb_cnt), 32'd48);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        clear_cnts(); expect_frame();
        pulse_start();
        wait_idle("after_held");
        frame_checks("after_held", 0);

        while (!b_done) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/orb_word_reader.md
ORB_WORD_READER -- requirements
Module: orb_word_reader

Interface
REQ-001 SHALL have parameter FRAME_WORDS, default 2048, meaning the number of RAM words per frame (addresses 0..FRAME_WORDS-1, at most 2048).
REQ-002 SHALL have parameter BIT_DIV, default 4, meaning clk cycles per serial bit (at least 2).
REQ-003 SHALL have parameter SYNC_WORD, default 12'hF0F, meaning the word sent in slot 0 in place of RAM address 0.
REQ-004 SHALL provide clk  in  1  system clock; all logic on its rising edge.
REQ-005 SHALL provide rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL provide start  in  1  asynchronous frame request level; a rising edge requests one frame.
REQ-007 SHALL provide rdData  in  12  RAM read data, valid one clk after RE.
REQ-008 SHALL provide rdAddr  out  11  RAM read address.
REQ-009 SHALL provide RE  out  1  RAM read enable, one-cycle pulse.
REQ-010 SHALL provide serOut  out  1  serial data, MSB first.
REQ-011 SHALL provide bitStrb  out  1  one-cycle pulse on the first clk of each serial bit.
REQ-012 SHALL provide frameSync  out  1  high for the whole serialization of slot 0.
REQ-013 SHALL provide busy  out  1  high from frame acceptance until the last bit of the last slot completes.
REQ-014 SHALL provide test  out  1  one-cycle pulse when a start edge arrives while busy (overrun).

Function
REQ-015 SHALL pass start through a 2-FF synchronizer; an edge is detected as sync[1]=1 with the previous sync[1]=0.
REQ-016 SHALL implement the states IDLE, FETCH, LATCH, SHIFT and NEXT.
REQ-017 IDLE: on a detected edge SHALL set busy=1, set the slot counter to 0, and go to LATCH (slot 0 needs no RAM read).
REQ-018 FETCH: SHALL drive rdAddr=slot with RE=1 for exactly one clk, then go to LATCH.
REQ-019 LATCH: SHALL load the 12-bit shift register with SYNC_WORD if slot==0, else with rdData; SHALL clear the bit and divider counters; SHALL go to SHIFT.
REQ-020 SHIFT: SHALL present shift[11] on serOut for BIT_DIV clk per bit, and pulse bitStrb on the first clk of each bit.
REQ-021 SHIFT: after 12 bits SHALL go to NEXT.
REQ-022 NEXT: if slot==FRAME_WORDS-1, SHALL set slot=0, clear busy and go to IDLE; otherwise SHALL increment slot and go to FETCH.
REQ-023 serOut SHALL be 0 in every state other than SHIFT; the inter-word gap SHALL be exactly 3 clk (NEXT, FETCH, LATCH).
REQ-024 frameSync SHALL be high in every SHIFT cycle for slot 0 and low otherwise.
REQ-025 Start edges in any state other than IDLE SHALL be ignored and SHALL pulse test for 1 clk.
REQ-026 The slot counter SHALL be 11 bits and SHALL wrap to 0 only through the REQ-022 rule.
REQ-027 RE SHALL never be asserted for address 0.
REQ-028 A start edge coincident with the NEXT-to-IDLE transition SHALL be treated as overrun (test pulse) and SHALL NOT start a frame.

Reset
REQ-029 While rst=1: state=IDLE, rdAddr=0, RE=0, serOut=0, bitStrb=0, frameSync=0, busy=0, test=0, all counters=0, shift register=0, synchronizer=0.
REQ-030 Asserting rst mid-frame SHALL abort immediately; after release, a new start edge SHALL begin at slot 0.

Structure
REQ-031 Shared package orb_pkg SHALL hold the state encoding, WORD_BITS=12, ADDR_BITS=11 and the SYNC_WORD default; the RAM writer shall use the same widths.
REQ-032 A sub-module orb_bit_timer SHALL generate the BIT_DIV divider and the bitStrb pulse; all other logic SHALL be in a single FSM.

Verification
REQ-033 FRAME_WORDS=4, BIT_DIV=4, RAM[1..3]=12'hABC,12'h001,12'h800, one start edge -> serOut shows F0F, ABC, 001, 800 MSB first, 48 bitStrb pulses, busy falls after the last bit.
REQ-034 Check RE pulses at addresses 1, 2, 3 only, each followed after 1 clk by LATCH; inter-word gap = 3 clk; frameSync high exactly 48 clk.
REQ-035 Second start edge mid-frame -> test pulses 1 clk, frame content unchanged, no extra frame.
REQ-036 rst pulse during slot 2 -> all outputs 0 next clk; new start -> frame restarts with SYNC_WORD.
REQ-037 FRAME_WORDS=2048 -> slot counter reaches 2047, RE at 11'd2047, then returns to IDLE with rdAddr=0.
REQ-038 start held high across the frame end -> no second frame until start falls and rises again.
